// File: rtl/fifo_drain_pkg.sv
// ---------------------------------------------------------------------------
// fifo_drain_pkg
//   Shared definitions for the fifo_drain block:
//     state_t - control FSM state (IDLE / FILL / FULL)
//     CNT_W   - width of the optional pop counter (word_cnt)
// ---------------------------------------------------------------------------
package fifo_drain_pkg;

    // IDLE : nothing buffered and nothing in flight
    // FILL : words buffered or in flight, room for more requests
    // FULL : buffered + in-flight words fill the output buffer, no requests
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    localparam int CNT_W = 16;

endpackage

// File: rtl/fifo_drain_buf.sv
// ---------------------------------------------------------------------------
// drain_buf
//   Small circular output buffer of O+1 words of M+1 bits with a wrapping
//   head pointer, a wrapping tail pointer and an occupancy register.
//
// Ports
//   r_clk    in   clock, rising edge
//   r_reset  in   asynchronous active-low reset
//   flush    in   empty the buffer at the next edge, ignoring any push
//   push     in   write wr_data at the tail at the next edge
//   wr_data  in   [M:0] word to write
//   rd_ready in   consumer accepts rd_data (pop when rd_valid is high)
//   rd_valid out  buffer not empty
//   rd_data  out  [M:0] word at head (0 when the buffer is empty)
//   occ      out  current occupancy, 0..O+1
//   occ_nxt  out  occupancy after the coming edge
// ---------------------------------------------------------------------------
module drain_buf #(
    parameter int M = 7,
    parameter int O = 2
) (
    input  logic                      r_clk,
    input  logic                      r_reset,
    input  logic                      flush,
    input  logic                      push,
    input  logic [M:0]                wr_data,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [M:0]                rd_data,
    output logic [$clog2(O+2)-1:0]    occ,
    output logic [$clog2(O+2)-1:0]    occ_nxt
);

    localparam int OCC_W = $clog2(O + 2);
    localparam int PTR_W = (O == 0) ? 1 : $clog2(O + 1);

    logic [M:0]       mem [0:O];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             pop;
    logic             push_eff;

    // Pointer increment that wraps after the last entry (O), so the depth
    // need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(O)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign rd_valid = (occ_q != '0);
    // Gated so the output reads 0 whenever nothing is buffered (including
    // during reset), since the storage itself is not reset.
    assign rd_data  = rd_valid ? mem[head_q] : '0;
    assign occ      = occ_q;
    assign occ_nxt  = occ_d;

    always_comb begin
        pop      = rd_valid && rd_ready;
        push_eff = push && !flush;
        head_d   = head_q;
        tail_d   = tail_q;
        occ_d    = occ_q;
        if (flush) begin
            // Collapse the buffer onto the current tail.
            head_d = tail_q;
            occ_d  = '0;
        end else begin
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            if (push_eff) begin
                tail_d = ptr_inc(tail_q);
            end
            case ({push_eff, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge r_clk) begin
        if (push_eff) begin
            mem[tail_q] <= wr_data;
        end
    end

endmodule

// File: rtl/fifo_drain.sv
// ---------------------------------------------------------------------------
// fifo_drain
//   Drains a FIFO with one-cycle read latency into a valid/ready stream.
//   Requests (r_en) are issued only while the output buffer has room for
//   every word already buffered or in flight, so r_en never depends on
//   m_ready and no returning word can be lost.
//
// Ports
//   r_clk    in   clock, rising edge
//   r_reset  in   asynchronous active-low reset
//   empty    in   FIFO read-side empty flag
//   dout     in   [M:0] FIFO read data, valid the cycle after r_en
//   r_en     out  FIFO pop request
//   flush    in   discard all buffered and in-flight words at the next edge
//   m_valid  out  stream word available
//   m_data   out  [M:0] stream word
//   m_ready  in   consumer accepts m_data
//   word_cnt out  [15:0] pop count (only with FIFO_DRAIN_CNT_EN)
//   ovf      out  sticky wrap flag of word_cnt (only with FIFO_DRAIN_CNT_EN)
//
// Build option
//   FIFO_DRAIN_CNT_EN : adds the word_cnt / ovf pop counter. Flush does not
//   clear it; reset does.
// ---------------------------------------------------------------------------
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int M = 7,
    parameter int O = 2
) (
    input  logic             r_clk,
    input  logic             r_reset,
    input  logic             empty,
    input  logic [M:0]       dout,
    output logic             r_en,
    input  logic             flush,
    output logic             m_valid,
    output logic [M:0]       m_data,
    input  logic             m_ready
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [CNT_W-1:0] word_cnt,
    output logic             ovf
`endif
);

    localparam int OCC_W = $clog2(O + 2);
    localparam logic [OCC_W:0] CAP = (OCC_W + 1)'(O + 1);

    logic             inflight_q, inflight_d;
    logic             armed_q, armed_d;
    state_t           state_q, state_d;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_nxt;
    logic [OCC_W:0]   load_nxt;

    drain_buf #(
        .M (M),
        .O (O)
    ) u_buf (
        .r_clk    (r_clk),
        .r_reset  (r_reset),
        .flush    (flush),
        .push     (inflight_q),
        .wr_data  (dout),
        .rd_ready (m_ready),
        .rd_valid (m_valid),
        .rd_data  (m_data),
        .occ      (occ),
        .occ_nxt  (occ_nxt)
    );

    // FULL is entered exactly when occ + inflight reaches O+1, so testing
    // the state register is the same as comparing the sum against the cap.
    // armed_q holds requests off for the first cycle after reset release.
    always_comb begin
        r_en       = armed_q && !empty && !flush && (state_q != FULL);
        inflight_d = r_en;
        armed_d    = 1'b1;
        load_nxt   = {1'b0, occ_nxt} + {{OCC_W{1'b0}}, inflight_d};
        if (load_nxt == '0) begin
            state_d = IDLE;
        end else if (load_nxt == CAP) begin
            state_d = FULL;
        end else begin
            state_d = FILL;
        end
    end

    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            inflight_q <= 1'b0;
            armed_q    <= 1'b0;
            state_q    <= IDLE;
        end else begin
            inflight_q <= inflight_d;
            armed_q    <= armed_d;
            state_q    <= state_d;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             cnt_pop;

    always_comb begin
        cnt_pop = m_valid && m_ready;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (cnt_pop) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == {CNT_W{1'b1}}) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge r_clk or negedge r_reset) begin
        if (!r_reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign word_cnt = cnt_q;
    assign ovf      = ovf_q;
`else
    // Pop counter not built.
`endif

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;
    import fifo_drain_pkg::*;

    localparam int M = 7;
    localparam int O = 2;

    logic       r_clk = 1'b0;
    logic       r_reset;
    logic       empty;
    logic [M:0] dout;
    logic       r_en;
    logic       flush;
    logic       m_valid;
    logic [M:0] m_data;
    logic       m_ready;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] word_cnt;
    logic        ovf;
`endif

    fifo_drain #(.M(M), .O(O)) dut (
        .r_clk   (r_clk),
        .r_reset (r_reset),
        .empty   (empty),
        .dout    (dout),
        .r_en    (r_en),
        .flush   (flush),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .word_cnt(word_cnt),
        .ovf     (ovf)
`endif
    );

    always #5 r_clk = ~r_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: a queue of buffered words, an in-flight flag, an
    // "armed" flag for the first cycle after reset, and a pop count.
    logic [M:0] mq[$];
    bit         m_infl;
    bit         m_armed;
    int         m_pops;

    // Source FIFO model: words 8'h11, 8'h22, ... returned one cycle after r_en.
    int         src_avail;
    logic [M:0] val_next;
    logic [M:0] pend_val;
    bit         rd_pending;

    logic       obs_r_en;
    logic       obs_m_valid;
    logic [M:0] obs_m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic state_t exp_state();
        int load;
        load = mq.size() + int'(m_infl);
        if (load == 0)      return IDLE;
        if (load == O + 1)  return FULL;
        return FILL;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit fl, input bit rdy);
        logic       exp_r_en;
        logic       exp_v;
        logic [M:0] exp_d;
        bit         pop;
        dout    = rd_pending ? pend_val : 8'hEE;
        empty   = (src_avail == 0);
        flush   = fl;
        m_ready = rdy;
        #1;
        exp_v    = (mq.size() != 0);
        exp_d    = exp_v ? mq[0] : '0;
        exp_r_en = m_armed && !empty && !fl && ((mq.size() + int'(m_infl)) < O + 1);
        obs_r_en    = r_en;
        obs_m_valid = m_valid;
        obs_m_data  = m_data;
        chk("r_en", 32'(r_en), 32'(exp_r_en));
        chk("m_valid", 32'(m_valid), 32'(exp_v));
        if (exp_v) chk("m_data", 32'(m_data), 32'(exp_d));
        chk("state", 32'(dut.state_q), 32'(exp_state()));
`ifdef FIFO_DRAIN_CNT_EN
        chk("word_cnt", 32'(word_cnt), 32'(16'(m_pops)));
        chk("ovf", 32'(ovf), 32'(m_pops >= 65536));
`endif
        $display("cyc t=%0t fl=%0b rdy=%0b dout=%02h r_en=%0b m_valid=%0b m_data=%02h",
                 $time, fl, rdy, dout, r_en, m_valid, m_data);
        // model update for the coming edge
        pop = exp_v && rdy;
        if (pop) begin
            void'(mq.pop_front());
            m_pops++;
        end
        if (fl) begin
            mq.delete();
            m_infl = 1'b0;
        end else begin
            if (m_infl) mq.push_back(dout);
            m_infl = exp_r_en;
        end
        m_armed = 1'b1;
        // the source FIFO answers whatever the DUT actually requested
        if (r_en) begin
            src_avail--;
            pend_val   = val_next;
            val_next   = val_next + 8'h11;
            rd_pending = 1'b1;
        end else begin
            rd_pending = 1'b0;
        end
        @(negedge r_clk);
    endtask

    task automatic do_reset();
        empty   = 1'b0;
        flush   = 1'b0;
        r_reset = 1'b0;
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'(1'b0));
        chk("rst_r_en", 32'(r_en), 32'(1'b0));
        chk("rst_m_data", 32'(m_data), 32'(8'h00));
        mq.delete();
        m_infl     = 1'b0;
        m_armed    = 1'b0;
        m_pops     = 0;
        rd_pending = 1'b0;
        @(posedge r_clk);
        @(negedge r_clk);
        r_reset = 1'b1;
    endtask

    task automatic drain();
        src_avail = 0;
        repeat (6) step(1'b0, 1'b1);
    endtask

    initial begin
        int n;
        r_reset    = 1'b1;
        empty      = 1'b1;
        flush      = 1'b0;
        m_ready    = 1'b0;
        dout       = '0;
        src_avail  = 0;
        val_next   = 8'h11;
        pend_val   = '0;
        rd_pending = 1'b0;
        #2;
        do_reset();

        // S1: streaming with latency 3
        val_next  = 8'h11;
        src_avail = 1000;
        step(1'b0, 1'b1); chk("s1_c0_r_en", 32'(obs_r_en), 32'(1'b0));
        step(1'b0, 1'b1); chk("s1_c1_r_en", 32'(obs_r_en), 32'(1'b1));
        step(1'b0, 1'b1); chk("s1_c2_m_valid", 32'(obs_m_valid), 32'(1'b0));
        step(1'b0, 1'b1); chk("s1_c3_m_valid", 32'(obs_m_valid), 32'(1'b1));
                          chk("s1_c3_data", 32'(obs_m_data), 32'(8'h11));
        step(1'b0, 1'b1); chk("s1_c4_data", 32'(obs_m_data), 32'(8'h22));
        step(1'b0, 1'b1); chk("s1_c5_data", 32'(obs_m_data), 32'(8'h33));
        repeat (6) step(1'b0, 1'b1);
        drain();

        // S2: back-pressure fills to FULL after exactly 3 requests
        val_next  = 8'h11;
        src_avail = 1000;
        n = 0;
        repeat (8) begin
            step(1'b0, 1'b0);
            if (obs_r_en) n++;
        end
        chk("s2_r_en_pulses", 32'(n), 32'(3));
        chk("s2_hold_data", 32'(obs_m_data), 32'(8'h11));
        chk("s2_full", 32'(dut.state_q), 32'(FULL));
        step(1'b0, 1'b1); chk("s2_first_out", 32'(obs_m_data), 32'(8'h11));
        step(1'b0, 1'b1); chk("s2_second_out", 32'(obs_m_data), 32'(8'h22));
        drain();

        // S3: source runs dry after 2 words
        val_next  = 8'h11;
        src_avail = 2;
        n = 0;
        repeat (8) begin
            step(1'b0, 1'b1);
            if (obs_m_valid) n++;
        end
        chk("s3_words", 32'(n), 32'(2));
        chk("s3_valid_end", 32'(obs_m_valid), 32'(1'b0));
        chk("s3_idle", 32'(dut.state_q), 32'(IDLE));
        drain();

        // S4: flush drops the returning word
        val_next  = 8'h11;
        src_avail = 1000;
        step(1'b0, 1'b1); chk("s4_c0_r_en", 32'(obs_r_en), 32'(1'b1));
        step(1'b1, 1'b1); chk("s4_c1_r_en", 32'(obs_r_en), 32'(1'b0));
        step(1'b0, 1'b1); chk("s4_c2_m_valid", 32'(obs_m_valid), 32'(1'b0));
        step(1'b0, 1'b1);
        step(1'b0, 1'b1); chk("s4_c4_m_valid", 32'(obs_m_valid), 32'(1'b1));
                          chk("s4_c4_data", 32'(obs_m_data), 32'(8'h22));
        repeat (4) step(1'b0, 1'b1);
        drain();

        // S5: reset mid-transfer with two words buffered
        val_next  = 8'h11;
        src_avail = 1000;
        repeat (3) step(1'b0, 1'b0);
        chk("s5_pre_m_valid", 32'(m_valid), 32'(1'b1));
        do_reset();
        step(1'b0, 1'b1); chk("s5_c0_r_en", 32'(obs_r_en), 32'(1'b0));
        step(1'b0, 1'b1); chk("s5_c1_r_en", 32'(obs_r_en), 32'(1'b1));
        repeat (4) step(1'b0, 1'b1);

`ifdef FIFO_DRAIN_CNT_EN
        // S6: counter wrap after 65537 pops
        src_avail = 1000000;
        for (int i = 0; i < 70000 && m_pops < 65537; i++) step(1'b0, 1'b1);
        chk("s6_word_cnt", 32'(word_cnt), 32'(16'd1));
        chk("s6_ovf", 32'(ovf), 32'(1'b1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 The block SHALL be parameterised by M, default 7, the data MSB index, giving data width M+1.
REQ-002 The block SHALL be parameterised by O, default 2, the output buffer depth minus one, giving depth O+1.
REQ-003 Port r_clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 Port r_reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port empty, input, 1 bit: the FIFO read-side empty flag.
REQ-006 Port dout, input, [M:0]: FIFO read data, valid in the cycle after r_en was high.
REQ-007 Port r_en, output, 1 bit: the FIFO pop request.
REQ-008 Port flush, input, 1 bit: synchronous discard of all buffered and in-flight words.
REQ-009 Port m_valid, output, 1 bit: a stream word is available.
REQ-010 Port m_data, output, [M:0]: the stream word.
REQ-011 Port m_ready, input, 1 bit: the stream consumer accepts the word.

Function
REQ-012 r_en SHALL equal !empty && !flush && (occ + inflight < O+1), where occ is the buffer occupancy register and inflight is a 1-bit register.
- r_en SHALL be a function of registers and of empty/flush only.
- r_en SHALL never depend on m_ready.
REQ-013 inflight SHALL be loaded with r_en each cycle.
REQ-014 When inflight=1, dout SHALL be written into the buffer tail at that cycle's edge.
REQ-015 Latency SHALL be as follows: r_en in cycle c gives dout captured at the end of c+1, and m_valid high in c+2 at the earliest.
REQ-016 The buffer SHALL be a circular array of O+1 entries with a wrapping head pointer, a wrapping tail pointer and occ (0..O+1).
- m_valid SHALL be (occ!=0).
- m_data SHALL be the entry at head, stable while m_valid && !m_ready.
REQ-017 A pop SHALL occur when m_valid && m_ready.
- On a pop, head SHALL advance modulo O+1.
REQ-018 If a push and a pop occur in the same cycle, occ SHALL be unchanged, and both pointers SHALL advance.
REQ-019 The control FSM SHALL have these states:
- IDLE: occ=0 and inflight=0.
- FILL: words in flight or buffered, below the cap.
- FULL: occ+inflight = O+1, so r_en is low.
- Transitions SHALL be derived from next-cycle occ and inflight.
REQ-020 In steady state with empty=0 and m_ready=1, the block SHALL sustain one word per cycle.
REQ-021 Data SHALL emerge in FIFO order, with no loss or duplication.
REQ-022 On flush=1, at the next edge:
- occ SHALL become 0, head SHALL equal tail, and inflight SHALL be 0.
- Any dout returning for a prior r_en SHALL be dropped.
- m_valid SHALL be 0 in the following cycle.
REQ-023 Words popped from the FIFO are consumed. A flush discards them; it is not a fault.
REQ-024 If empty rises while inflight=1, the in-flight word SHALL still be captured.

Reset
REQ-025 While r_reset=0, asynchronously:
- occ, head, tail and inflight SHALL be 0, and the FSM SHALL be in IDLE.
- r_en SHALL be 0, m_valid SHALL be 0, and m_data SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL discard buffered and in-flight words, with no r_en in the first cycle after release.

Configuration
REQ-027 With FIFO_DRAIN_CNT_EN defined, the block SHALL add these ports:
- output word_cnt [15:0]: counts pops, wraps at 16'hFFFF to 0, is cleared by reset, and is not cleared by flush.
- output ovf: sticky, set when word_cnt wraps.
REQ-028 Without FIFO_DRAIN_CNT_EN, these ports and the counter logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-029 Package fifo_drain_pkg SHALL hold the FSM state typedef (IDLE, FILL, FULL) and the counter width constant (16).
REQ-030 The buffer SHALL be a sub-module drain_buf (storage, pointers, occ).
- fifo_drain SHALL hold the FSM, the r_en/inflight logic and the optional counter.

Verification
REQ-031 The bench SHALL cover each of these directed scenarios:
- Reset, then empty=0 with dout = 8'h11, 22, 33…, and m_ready=1 -> r_en high from cycle 1, m_valid from cycle 3, then one word per cycle in order.
- m_ready=0 with a non-empty FIFO -> exactly 3 r_en pulses, then r_en=0 in FULL; m_data holds 8'h11 until m_ready=1.
- The FIFO goes empty after 2 pops, with m_ready=1 -> exactly 2 words out, then m_valid=0 and the FSM in IDLE.
- flush on the cycle after r_en -> the returning word is dropped and m_valid=0 the next cycle; following words are unaffected.
- r_reset pulsed low with occ=2 -> m_valid=0 immediately and r_en=0 for one cycle after release.
- With FIFO_DRAIN_CNT_EN, 65537 pops -> word_cnt=1 and ovf=1.
